// File: rtl/ps2_scan_rx_if.sv
// Key-event bus from the PS/2 receiver to the key tracking logic.
// Latency: none, pure signal bundle.
// Backpressure: none; consumers must take keyValid/error strobes when they occur.
interface ps2_scan_rx_if;
   logic [7:0] keyData;
   logic       press;
   logic       ext;
   logic       keyValid;
   logic       parity_err;
   logic       frame_err;

   modport master (output keyData, press, ext, keyValid, parity_err, frame_err);
   modport slave  (input  keyData, press, ext, keyValid, parity_err, frame_err);
endinterface

// File: rtl/ps2_scan_rx.sv
// Host-side PS/2 keyboard receiver: deserialises 11-bit frames, strips F0/E0 prefixes, emits key events.
// Latency: keyValid rises one clk after the cycle in which the stop-bit falling edge is seen.
// Backpressure: none; events and error strobes are single-cycle and must be sampled when asserted.
// Build option: define PS2_EXTENDED_EN to track the 0xE0 prefix and report it on ext.
module ps2_scan_rx #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          ps2_clk,
   input  logic          ps2_data,
   ps2_scan_rx_if.master key_bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;
   logic                   clk_s;
   logic                   data_s;
   logic                   fe;

   state_t                 state_q;
   state_t                 state_d;
   logic [7:0]             shift_q;
   logic [2:0]             bit_cnt;
   logic                   par_q;
   logic [TW-1:0]          to_cnt;
   logic                   timeout;
   logic                   stop_fe;
   logic                   byte_ok;
   logic                   break_pend;

   assign clk_s   = clk_sync[SYNC_STAGES-1];
   assign data_s  = data_sync[SYNC_STAGES-1];
   assign fe      = clk_prev & ~clk_s;
   // Stop bit must be 1 and data plus parity must carry an odd number of ones.
   assign byte_ok = data_s & (^{shift_q, par_q});

   // Synchronise the raw lines; preset high so reset never fakes a falling edge.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
         clk_prev  <= clk_s;
      end
   end

   // Frame state register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state; a falling edge in the same cycle as the timeout wins.
   always_comb begin
      state_d = state_q;
      timeout = 1'b0;
      stop_fe = 1'b0;
      if (state_q != IDLE && !fe && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
         timeout = 1'b1;
         state_d = IDLE;
      end else if (fe) begin
         case (state_q)
            IDLE:    if (!data_s) state_d = DATA;
            DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
            PARITY:  state_d = STOP;
            STOP: begin
               state_d = IDLE;
               stop_fe = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Shift register, bit counter and parity capture, all advanced on falling edges only.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         shift_q <= '0;
         bit_cnt <= '0;
         par_q   <= 1'b0;
      end else if (fe) begin
         case (state_q)
            IDLE: if (!data_s) begin
               shift_q <= '0;
               bit_cnt <= '0;
            end
            DATA: begin
               shift_q <= {data_s, shift_q[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
            end
            PARITY:  par_q <= data_s;
            default: ;
         endcase
      end
   end

   // Inactivity timer: idles at zero and restarts on every keyboard clock edge.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)                      to_cnt <= '0;
      else if (state_q == IDLE || fe)  to_cnt <= '0;
      else                             to_cnt <= to_cnt + TW'(1);
   end

   // Code layer: prefix tracking, held key outputs and single-cycle strobes.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         break_pend          <= 1'b0;
         key_bus.keyData     <= '0;
         key_bus.press       <= 1'b0;
         key_bus.keyValid    <= 1'b0;
         key_bus.parity_err  <= 1'b0;
         key_bus.frame_err   <= 1'b0;
      end else begin
         key_bus.keyValid   <= 1'b0;
         key_bus.parity_err <= 1'b0;
         key_bus.frame_err  <= 1'b0;
         if (timeout) begin
            key_bus.frame_err <= 1'b1;
            break_pend        <= 1'b0;
         end else if (stop_fe) begin
            if (!byte_ok) begin
               key_bus.parity_err <= 1'b1;
               break_pend         <= 1'b0;
            end else if (shift_q == 8'hF0) begin
               break_pend <= 1'b1;
            end else if (shift_q != 8'hE0) begin
               key_bus.keyData  <= shift_q;
               key_bus.press    <= ~break_pend;
               key_bus.keyValid <= 1'b1;
               break_pend       <= 1'b0;
            end
         end
      end
   end

`ifdef PS2_EXTENDED_EN
   logic ext_pend;

   // Extended-prefix tracking; ext is held alongside keyData.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         ext_pend    <= 1'b0;
         key_bus.ext <= 1'b0;
      end else if (timeout || (stop_fe && !byte_ok)) begin
         ext_pend <= 1'b0;
      end else if (stop_fe) begin
         if (shift_q == 8'hE0) begin
            ext_pend <= 1'b1;
         end else if (shift_q != 8'hF0) begin
            key_bus.ext <= ext_pend;
            ext_pend    <= 1'b0;
         end
      end
   end
`else
   assign key_bus.ext = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: drives PS/2 frames bit by bit and checks key events and strobes.
module tb_ps2_scan_rx;
   localparam int HALF = 20;
   localparam int TMO  = 300;

   logic Clk      = 1'b0;
   logic Reset    = 1'b0;
   logic ps2_clk  = 1'b1;
   logic ps2_data = 1'b1;

   ps2_scan_rx_if key_bus();

   ps2_scan_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .key_bus  (key_bus)
   );

   always #5 Clk = ~Clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int kv_cnt = 0, pe_cnt = 0, fr_cnt = 0, overlap = 0, wide = 0;
   int last_kv_cyc = 0, last_fall_cyc = 0;
   logic kv_prev = 1'b0, pe_prev = 1'b0, fr_prev = 1'b0;
   logic ext_exp;

   always @(posedge Clk) cyc++;

   // Strobe monitor, sampled away from the active edge.
   always @(negedge Clk) begin
      if (key_bus.keyValid) begin
         kv_cnt++;
         last_kv_cyc = cyc;
      end
      if (key_bus.parity_err) pe_cnt++;
      if (key_bus.frame_err)  fr_cnt++;
      if ((int'(key_bus.keyValid) + int'(key_bus.parity_err) + int'(key_bus.frame_err)) > 1) overlap++;
      if ((key_bus.keyValid && kv_prev) || (key_bus.parity_err && pe_prev) ||
          (key_bus.frame_err && fr_prev)) wide++;
      kv_prev = key_bus.keyValid;
      pe_prev = key_bus.parity_err;
      fr_prev = key_bus.frame_err;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_bits(input logic [10:0] fr, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk);
         ps2_data = fr[i];
         repeat (HALF) @(negedge Clk);
         ps2_clk = 1'b0;
         last_fall_cyc = cyc;
         repeat (HALF) @(negedge Clk);
         ps2_clk = 1'b1;
      end
      @(negedge Clk);
      ps2_data = 1'b1;
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] b, input logic good);
      logic par;
      par = good ? ~(^b) : (^b);
      return {1'b1, par, b, 1'b0};
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic good);
      send_bits(make_frame(b, good), 11);
      repeat (10) @(negedge Clk);
   endtask

   initial begin
`ifdef PS2_EXTENDED_EN
      ext_exp = 1'b1;
`else
      ext_exp = 1'b0;
`endif
      repeat (3) @(negedge Clk);
      check("rst_keyData", 32'(key_bus.keyData), 32'h0);
      check("rst_press",   32'(key_bus.press), 32'h0);
      check("rst_ext",     32'(key_bus.ext), 32'h0);
      check("rst_strobes", {29'd0, key_bus.keyValid, key_bus.parity_err, key_bus.frame_err}, 32'h0);
      Reset = 1'b1;
      repeat (5) @(negedge Clk);

      // Plain make code.
      send_frame(8'h1C, 1'b1);
      check("make_cnt",     32'(kv_cnt), 32'd1);
      check("make_key",     32'(key_bus.keyData), 32'h1C);
      check("make_press",   32'(key_bus.press), 32'h1);
      check("make_ext",     32'(key_bus.ext), 32'h0);
      check("make_latency", 32'(last_kv_cyc - last_fall_cyc), 32'd3);
      check("make_noerr",   32'(pe_cnt + fr_cnt), 32'd0);

      // Break sequence F0 1C.
      send_frame(8'hF0, 1'b1);
      check("f0_nostrobe", 32'(kv_cnt), 32'd1);
      send_frame(8'h1C, 1'b1);
      check("brk_cnt",   32'(kv_cnt), 32'd2);
      check("brk_key",   32'(key_bus.keyData), 32'h1C);
      check("brk_press", 32'(key_bus.press), 32'h0);

      // Bad parity on 0x23, then a good 0x23.
      send_frame(8'h23, 1'b0);
      check("par_err_cnt", 32'(pe_cnt), 32'd1);
      check("par_no_kv",   32'(kv_cnt), 32'd2);
      check("par_hold",    32'(key_bus.keyData), 32'h1C);
      send_frame(8'h23, 1'b1);
      check("par_next_key",   32'(key_bus.keyData), 32'h23);
      check("par_next_press", 32'(key_bus.press), 32'h1);

      // Partial frame abandoned on timeout.
      send_bits(make_frame(8'h55, 1'b1), 6);
      repeat (TMO + 50) @(negedge Clk);
      check("tmo_cnt",   32'(fr_cnt), 32'd1);
      check("tmo_no_kv", 32'(kv_cnt), 32'd3);
      check("tmo_hold",  32'(key_bus.keyData), 32'h23);
      send_frame(8'h4C, 1'b1);
      check("tmo_next_key",   32'(key_bus.keyData), 32'h4C);
      check("tmo_next_press", 32'(key_bus.press), 32'h1);

      // Extended break E0 F0 74.
      send_frame(8'hE0, 1'b1);
      check("e0_nostrobe", 32'(kv_cnt), 32'd4);
      send_frame(8'hF0, 1'b1);
      send_frame(8'h74, 1'b1);
      check("ext_cnt",   32'(kv_cnt), 32'd5);
      check("ext_key",   32'(key_bus.keyData), 32'h74);
      check("ext_press", 32'(key_bus.press), 32'h0);
      check("ext_flag",  32'(key_bus.ext), 32'(ext_exp));

      // Reset after F0 and 3 bits of the next frame.
      send_frame(8'hF0, 1'b1);
      send_bits(make_frame(8'h1B, 1'b1), 3);
      Reset = 1'b0;
      repeat (3) @(negedge Clk);
      check("mrst_key",   32'(key_bus.keyData), 32'h0);
      check("mrst_press", 32'(key_bus.press), 32'h0);
      check("mrst_ext",   32'(key_bus.ext), 32'h0);
      Reset = 1'b1;
      repeat (5) @(negedge Clk);
      send_frame(8'h1B, 1'b1);
      check("mrst_cnt",        32'(kv_cnt), 32'd6);
      check("mrst_next_key",   32'(key_bus.keyData), 32'h1B);
      check("mrst_next_press", 32'(key_bus.press), 32'h1);
      check("mrst_next_ext",   32'(key_bus.ext), 32'h0);

      // Global strobe properties.
      check("total_par_err",   32'(pe_cnt), 32'd1);
      check("total_frame_err", 32'(fr_cnt), 32'd1);
      check("strobe_excl",     32'(overlap), 32'd0);
      check("strobe_width",    32'(wide), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ps2_scan_rx.md
Name: ps2_scan_rx

Overview:
- Host-side PS/2 keyboard receiver. Deserialises the raw keyboard clock/data lines into 11-bit frames.
- Strips the 0xF0 break prefix and the 0xE0 extended prefix.
- Presents each key event as a held scancode plus a press/release flag. This is exactly the keyData/press pair consumed by the lane key-state register.
- Sits between the PS/2 connector pins and the key tracking logic.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchroniser on ps2_clk and ps2_data (min 2)
TIMEOUT_CYCLES, 50000, Clk cycles without a ps2_clk falling edge before a partial frame is abandoned (1 ms at 50 MHz)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
ps2_clk  in  1  raw keyboard clock, asynchronous
ps2_data  in  1  raw keyboard data, asynchronous
keyData  out  8  last non-prefix scancode; held until the next one
press  out  1  1 = make (pressed), 0 = break (released); held with keyData
ext  out  1  1 = keyData was preceded by 0xE0; held with keyData
keyValid  out  1  one-cycle strobe, new keyData/press/ext event
parity_err  out  1  one-cycle strobe, frame discarded for parity or stop bit
frame_err  out  1  one-cycle strobe, partial frame abandoned on timeout

Behaviour:
- Reset low (async): all outputs 0, FSM in IDLE, bit counter 0, timeout counter 0, break_pend = 0, ext_pend = 0, synchronisers preset to 1.
- Both lines pass through SYNC_STAGES flops. A falling edge (fe) is the synchronised clock going 1 in the previous cycle to 0 in the current cycle. All line sampling uses synchronised data in the fe cycle.
- Frame FSM:
  - IDLE: on fe with data 0 -> DATA, clear shift register and bit counter. On fe with data 1 -> stay in IDLE (glitch ignored).
  - DATA: on each fe, shift data in LSB first and increment the counter. After the 8th bit -> PARITY.
  - PARITY: on fe, capture the parity bit -> STOP.
  - STOP: on fe -> IDLE. Byte accepted only if stop = 1 and the XOR of 8 data bits plus parity = 1 (odd parity). Otherwise pulse parity_err and clear break_pend/ext_pend.
- Timeout:
  - The counter clears on every fe and while in IDLE.
  - In any non-IDLE state, reaching TIMEOUT_CYCLES-1 -> pulse frame_err, go to IDLE, clear break_pend/ext_pend.
  - If fe and timeout coincide, fe wins and no error is raised.
- Code layer, applied to each accepted byte in the cycle after the STOP fe:
  - 0xF0: set break_pend. No strobe. A repeated F0 stays set.
  - 0xE0: set ext_pend (see Optional Feature). No strobe.
  - Any other byte: keyData <= byte, press <= ~break_pend, ext <= ext_pend. keyValid = 1 for exactly one cycle. Then clear both pendings.
- Latency: keyValid rises one Clk after the cycle in which the stop-bit fe is detected.
- Held outputs change only on a keyValid cycle. Error strobes do not alter keyData/press/ext.
- Strobes are mutually exclusive and never exceed one cycle.
- Reset mid-frame drops the partial frame and any pending prefix. No strobe is emitted.

Optional Feature:
PS2_EXTENDED_EN
- Defined: 0xE0 sets ext_pend; ext reports it as described above.
- Undefined: 0xE0 is discarded as a prefix (no strobe, no flag), ext is tied to 0, and ext_pend logic is not built. E0 F0 74 therefore reports keyData = 0x74, press = 0.

Test Plan:
- Frame 0x1C, parity 0, stop 1 -> single keyValid, keyData = 0x1C, press = 1, ext = 0, no error strobes.
- Frames F0 then 1C -> no strobe after F0. One keyValid after 1C with keyData = 0x1C, press = 0.
- Frame 0x23 with parity bit 1 (even total) -> parity_err one cycle, no keyValid, keyData keeps its previous value. Next valid frame 0x23 decodes with press = 1.
- Start bit plus 5 data bits, then ps2_clk held high for TIMEOUT_CYCLES -> frame_err one cycle. A following full frame 0x4C gives keyData = 0x4C, press = 1.
- E0 F0 74 -> with PS2_EXTENDED_EN: keyData = 0x74, press = 0, ext = 1. Without it: keyData = 0x74, press = 0, ext = 0.
- Reset pulsed low after F0 and 3 bits of the next frame -> all outputs 0. Then 1B alone gives keyData = 0x1B, press = 1 (break_pend cleared by reset).
